// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants and types for the GPIO input conditioning path
//
// Purpose:
//   Widths, bit-field positions and debounce defaults shared by the
//   input conditioner, its per-bit debouncer and the MMIO register block.
//
// Contents:
//   GPIO_N                   number of conditioned inputs (4 buttons + 4 switches)
//   GPIO_BTN_LSB             first bit of the button field
//   GPIO_SW_LSB              first bit of the switch field
//   DEBOUNCE_CYCLES_DEFAULT  5 ms at 50 MHz
//   DEBOUNCE_CYCLES_SIM      short count so simulations stay fast
//   gpio_bit_status_t        conditioned view of one input bit
//   debounce_cnt_w()         counter width needed for a given debounce count

package gpio_pkg;

  localparam int GPIO_N                  = 8;
  localparam int GPIO_BTN_LSB            = 0;
  localparam int GPIO_SW_LSB             = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

  typedef struct packed {
    logic stable;
    logic rise;
    logic fall;
  } gpio_bit_status_t;

  // The counter only has to reach cycles-1, so clog2(cycles) bits suffice;
  // a single bit is kept for cycles==1 so the counter still has a legal width.
  function automatic int debounce_cnt_w(input int cycles);
    if (cycles <= 1) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - synchronizer, debouncer and edge detector for one input bit
//
// Purpose:
//   Brings one asynchronous pad input into the clk domain through two flops,
//   accepts a new level only after it has been seen for DEBOUNCE_CYCLES
//   consecutive cycles, and emits one-cycle registered pulses on each
//   accepted 0->1 / 1->0 change.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   raw_i     asynchronous raw pad input
//   stable_o  debounced level
//   rise_o    one-cycle pulse in the first cycle stable_o reads 1
//   fall_o    one-cycle pulse in the first cycle stable_o reads 0

module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  // Plain two-flop chain: nothing may sit between the flops or the
  // metastability settling window of sync1_q is eaten into.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // The counter measures how long sync2_q has disagreed with the accepted
  // level. Any agreement (a bounce back) clears it, so only an uninterrupted
  // run of DEBOUNCE_CYCLES disagreeing cycles moves the stable level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      stable_d = sync2_q;
      // Pulses are registered alongside stable_q so they line up with the
      // first cycle the new level is visible.
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Reset forces the level directly instead of flipping it, so it never
  // produces an edge pulse even when the previous level differed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - N-bit debounced GPIO input front end for the MMIO block
//
// Purpose:
//   Conditions raw board inputs before they reach the MMIO GPIO input
//   register. o_stable[3:0] feeds the button field, o_stable[7:4] the switch
//   field; o_rise/o_fall are provided for interrupt or sticky-flag logic.
//   Every bit is handled independently by its own gpio_debounce_bit.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   i_raw     [N-1:0] asynchronous raw pad inputs
//   o_stable  [N-1:0] debounced levels (RESET_VAL after reset)
//   o_rise    [N-1:0] one-cycle pulse per bit on an accepted 0->1 change
//   o_fall    [N-1:0] one-cycle pulse per bit on an accepted 1->0 change
//
// DEBOUNCE_CYCLES must be at least 1. All outputs are registered; there is no
// combinational path from i_raw to any output.

module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int           N               = GPIO_N,
  parameter int           DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [N-1:0] RESET_VAL       = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_raw,
  output logic [N-1:0] o_stable,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall
);

  gpio_bit_status_t bit_st [N];

  for (genvar g = 0; g < N; g++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_VAL[g])
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (i_raw[g]),
      .stable_o (bit_st[g].stable),
      .rise_o   (bit_st[g].rise),
      .fall_o   (bit_st[g].fall)
    );

    assign o_stable[g] = bit_st[g].stable;
    assign o_rise[g]   = bit_st[g].rise;
    assign o_fall[g]   = bit_st[g].fall;
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - self-checking bench for gpio_input_conditioner

module tb_gpio_input_conditioner;

  localparam int         D    = 4;
  localparam logic [7:0] RV   = 8'h00;
  localparam int         HMAX = 8192;

  logic       clk;
  logic       rst;
  logic [7:0] i_raw;
  logic [7:0] o_stable;
  logic [7:0] o_rise;
  logic [7:0] o_fall;

  int checks = 0;
  int errors = 0;

  gpio_input_conditioner #(
    .N               (8),
    .DEBOUNCE_CYCLES (D),
    .RESET_VAL       (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (i_raw),
    .o_stable (o_stable),
    .o_rise   (o_rise),
    .o_fall   (o_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembers what was applied at every edge and decides a
  // flip purely from the rule "the synchronized value (raw from two edges
  // earlier) differed from the accepted level on each of the last D edges,
  // all of them after the bit's last flip or reset".
  logic [7:0] raw_h [HMAX];
  bit         rst_h [HMAX];
  int         e_cnt = 0;
  int         last_evt [8];
  logic [7:0] rv_v = RV;
  logic [7:0] exp_stable = RV;
  logic [7:0] exp_rise = '0;
  logic [7:0] exp_fall = '0;
  bit         model_valid = 0;

  function automatic logic s2(int j, int b);
    if (j < 2) return rv_v[b];
    if (rst_h[j-1] || rst_h[j-2]) return rv_v[b];
    return raw_h[j-2][b];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (e_cnt < HMAX) begin
        raw_h[e_cnt] = i_raw;
        rst_h[e_cnt] = rst;
        for (int b = 0; b < 8; b++) begin
          if (rst) begin
            exp_stable[b] = rv_v[b];
            exp_rise[b]   = 1'b0;
            exp_fall[b]   = 1'b0;
            last_evt[b]   = e_cnt;
          end else begin
            bit flip;
            flip = 1'b1;
            for (int j = e_cnt - D + 1; j <= e_cnt; j++) begin
              if (j <= last_evt[b] || s2(j, b) == exp_stable[b]) flip = 1'b0;
            end
            exp_rise[b] = 1'b0;
            exp_fall[b] = 1'b0;
            if (flip) begin
              exp_stable[b] = ~exp_stable[b];
              exp_rise[b]   = exp_stable[b];
              exp_fall[b]   = ~exp_stable[b];
              last_evt[b]   = e_cnt;
            end
          end
        end
        e_cnt++;
        model_valid = 1'b1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        checks++;
        if (o_stable !== exp_stable || o_rise !== exp_rise || o_fall !== exp_fall) begin
          errors++;
          $display("FAIL model_cmp edge=%0d: stable/rise/fall got %h/%h/%h expected %h/%h/%h",
                   e_cnt, o_stable, o_rise, o_fall, exp_stable, exp_rise, exp_fall);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] acc;
  bit         noisy;

  initial begin
    rst   = 1'b1;
    i_raw = 8'hFF;

    // Reset with all inputs high: nothing during reset, one rise burst after.
    tick(1);
    chk("rst_stable", o_stable, 8'h00);
    chk("rst_rise", o_rise, 8'h00);
    chk("rst_fall", o_fall, 8'h00);
    tick(1);
    rst = 1'b0;
    tick(5);
    chk("post_rst_e4_stable", o_stable, 8'h00);
    tick(1);
    chk("post_rst_e5_stable", o_stable, 8'hFF);
    chk("post_rst_e5_rise", o_rise, 8'hFF);
    tick(1);
    chk("post_rst_e6_rise", o_rise, 8'h00);

    // Clean press on bit 0.
    rst = 1'b1;
    i_raw = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(8);
    i_raw = 8'h01;
    tick(5);
    chk("press_e4_stable", o_stable, 8'h00);
    tick(1);
    chk("press_e5_stable", o_stable, 8'h01);
    chk("press_e5_rise", o_rise, 8'h01);
    chk("press_e5_fall", o_fall, 8'h00);
    tick(1);
    chk("press_e6_rise", o_rise, 8'h00);

    // Bounce on bit 1, then settle low, then a real press.
    acc = '0;
    i_raw = 8'h03; tick(1); acc |= o_rise | o_fall;
    i_raw = 8'h01; tick(1); acc |= o_rise | o_fall;
    i_raw = 8'h03; tick(1); acc |= o_rise | o_fall;
    i_raw = 8'h01;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      acc |= o_rise | o_fall;
    end
    chk("bounce_stable", o_stable, 8'h01);
    chk("bounce_pulses", acc, 8'h00);
    i_raw = 8'h03;
    tick(5);
    chk("bounce_hold_e4_stable", o_stable, 8'h01);
    tick(1);
    chk("bounce_hold_e5_stable", o_stable, 8'h03);
    chk("bounce_hold_e5_rise", o_rise, 8'h02);

    // Release of bit 2, then a long hold with no repeat.
    i_raw = 8'h07;
    tick(8);
    i_raw = 8'h03;
    tick(5);
    chk("release_e4_fall", o_fall, 8'h00);
    tick(1);
    chk("release_e5_fall", o_fall, 8'h04);
    chk("release_e5_stable", o_stable, 8'h03);
    acc = '0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      acc |= o_rise | o_fall;
    end
    chk("hold_no_repeat", acc, 8'h00);

    // Simultaneous multi-bit change.
    i_raw = 8'h00;
    tick(8);
    i_raw = 8'hA5;
    tick(5);
    chk("multi_e4_stable", o_stable, 8'h00);
    tick(1);
    chk("multi_e5_stable", o_stable, 8'hA5);
    chk("multi_e5_rise", o_rise, 8'hA5);

    // Reset arriving while bit 3 is mid-count.
    i_raw = 8'h00;
    tick(8);
    i_raw = 8'h08;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_stable", o_stable, 8'h00);
    chk("midrst_pulses", o_rise | o_fall, 8'h00);
    rst = 1'b0;
    tick(5);
    chk("midrst_e4_stable", o_stable, 8'h00);
    tick(1);
    chk("midrst_e5_stable", o_stable, 8'h08);
    chk("midrst_e5_rise", o_rise, 8'h08);

    // Randomized phase: alternating noisy and calm stretches, rare resets.
    noisy = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) noisy = ~noisy;
      rst = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, noisy ? 2 : 19) == 0) i_raw[b] = ~i_raw[b];
      end
      tick(1);
    end
    rst = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Conditions raw board inputs (buttons, switches) before they reach the MMIO GPIO input register.
- Per bit: 2-flop synchronizer, then a counter-based debouncer, then edge detection.
- Sits directly upstream of the MMIO block.
  - o_stable[3:0] drives the MMIO button input.
  - o_stable[7:4] drives the MMIO switch input.
  - o_rise and o_fall are available for future interrupt/sticky-flag logic.

Parameters:
- N, 8, number of input bits (default covers 4 buttons + 4 switches).
- DEBOUNCE_CYCLES, 250000, consecutive cycles the synchronized input must differ from the stable value before the stable value flips. Must be >=1.
- RESET_VAL, 8'h00, value loaded into o_stable on reset (N bits wide).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- i_raw  input  N  asynchronous raw pad inputs.
- o_stable  output  N  debounced level.
- o_rise  output  N  one-cycle pulse when the matching o_stable bit goes 0->1.
- o_fall  output  N  one-cycle pulse when the matching o_stable bit goes 1->0.

Behaviour:
- Single clock domain clk; reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - sync1 = sync2 = RESET_VAL.
  - o_stable = RESET_VAL.
  - All counters = 0.
  - o_rise = o_fall = 0.
  - No pulse is generated by reset itself.
- Synchronizer, per bit: sync1 <= i_raw; sync2 <= sync1. No logic between the two flops.
- Counter width: CNT_W = max(1, clog2(DEBOUNCE_CYCLES)). The counter never exceeds DEBOUNCE_CYCLES-1.
- Debounce per bit, evaluated every edge:
  - sync2 == o_stable: cnt <= 0, o_stable holds.
  - sync2 != o_stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != o_stable and cnt == DEBOUNCE_CYCLES-1: o_stable <= sync2, cnt <= 0.
- Latency: raw change set up before edge 0 and held appears on o_stable after edge DEBOUNCE_CYCLES+1.
  - For DEBOUNCE_CYCLES=1 this is after edge 2, i.e. the synchronizer delay only.
- Glitch rejection: any return of sync2 to o_stable before the count completes clears cnt. The count restarts from 0 on the next difference.
- Edge pulses:
  - o_rise and o_fall are registered.
  - They are high for exactly the one cycle in which o_stable holds its new value: the cycle after the flip edge.
  - o_rise and o_fall are never high together on the same bit.
- Bits are fully independent. Simultaneous flips on several bits produce simultaneous pulses.
- Reset mid-count: the counter is discarded and o_stable is forced to RESET_VAL. No o_rise or o_fall is produced, even if the prior o_stable differed.
- A held input produces exactly one pulse. There is no auto-repeat.
- No combinational path from i_raw to any output.

Decomposition:
- Shared package gpio_pkg:
  - GPIO_N = 8.
  - GPIO_BTN_LSB = 0.
  - GPIO_SW_LSB = 4.
  - DEBOUNCE_CYCLES_DEFAULT = 250000 (5 ms at 50 MHz).
  - DEBOUNCE_CYCLES_SIM = 4.
- One sub-module, gpio_debounce_bit: sync chain, counter, stable flop and edge pulses for one bit.
  - The top instantiates it N times with a generate loop.

Test Plan:
- Reset behaviour, with DEBOUNCE_CYCLES=4, RESET_VAL=0:
  - Assert rst for 2 cycles with i_raw=8'hFF.
  - Required: o_stable=0x00, o_rise=o_fall=0 during reset.
  - After release, o_stable becomes 0xFF after edge 5 post-release.
  - o_rise=0xFF for exactly one cycle.
- Clean press:
  - Set i_raw[0]=1 before edge 0 and hold.
  - Required: o_stable[0]=1 after edge 5, o_rise[0]=1 for one cycle, o_fall=0.
  - Other bits unchanged.
- Bounce rejection:
  - Drive i_raw[1] as 1,0,1,0 on consecutive cycles, then hold at 0.
  - Required: o_stable[1] stays 0, no pulses.
  - Then hold at 1 for 6 cycles: o_stable[1]=1 with a single o_rise[1].
- Release:
  - From o_stable[2]=1, drive i_raw[2]=0 and hold.
  - Required: o_fall[2] one cycle, 5 edges later.
  - Holding for 100 further cycles produces no additional pulses.
- Simultaneous and independent bits:
  - i_raw goes 0x00->0xA5 in one cycle.
  - Required: o_stable=0xA5 after edge 5, o_rise=0xA5 for one cycle.
- Reset mid-count:
  - Drive i_raw[3]=1, assert rst at cnt=2.
  - Required: o_stable[3]=0 with no pulse.
  - After release, o_stable[3]=1 after the full 5-edge latency, not earlier.
